aes_spi_frame_loader: RTL

//   Serial front end for the AES cipher/inverse-cipher cores. Shifts one frame
//   (128-bit data block, then Nk*32-bit key) in LSB-first from the mosi pin,

---
 rtl/aes_pkg.sv | 25 ++
 rtl/serial_capture_reg.sv | 25 ++
 rtl/aes_spi_frame_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and sizing helpers for the AES serial front end.
// Imported by the frame loader and its capture registers.
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int NB      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      KEY  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Round count for a key of nk 32-bit words (10/12/14).
   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   // Total serial bits in one frame: data block followed by the key.
   function automatic int frame_bits_of(input int nk);
      return BLOCK_W + nk * 32;
   endfunction

endpackage

// File: rtl/serial_capture_reg.sv
// W-bit register that writes a single addressed bit per enabled cycle.
// Used once for the data block and once for the key.
module serial_capture_reg
   import aes_pkg::*;
#(
   parameter int W  = 128,
   parameter int IW = $clog2(W)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [IW-1:0] idx,
   input  logic          bit_in,
   output logic [W-1:0]  q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q[idx] <= bit_in;
      end
   end

endmodule

// File: rtl/aes_spi_frame_loader.sv
// Serial LSB-first loader of one AES frame (data block then key), handed to the
// cipher core through a valid/ready handshake.
module aes_spi_frame_loader
   import aes_pkg::*;
#(
   parameter int NK      = 4,
   parameter int BLOCK_W = aes_pkg::BLOCK_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cs,
   input  logic                mosi,
   output logic [BLOCK_W-1:0]  data_out,
   output logic [NK*32-1:0]    key_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                frame_err
);

   localparam int KEY_W = NK * 32;
   localparam int CNT_W = $clog2(frame_bits_of(NK));
   localparam int DIW   = $clog2(BLOCK_W);
   localparam int KIW   = $clog2(KEY_W);

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BLOCK_W - 1);
   localparam logic [CNT_W-1:0] LAST_KEY  = CNT_W'(KEY_W - 1);

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;

   logic             data_en;
   logic             key_en;
   logic [DIW-1:0]   data_idx;
   logic [KIW-1:0]   key_idx;

   // The first bit of a frame is taken in IDLE and always lands at position 0.
   always_comb begin
      data_en  = ~cs & ((state == IDLE) | (state == DATA));
      key_en   = ~cs & (state == KEY);
      data_idx = (state == IDLE) ? '0 : bit_cnt[DIW-1:0];
      key_idx  = bit_cnt[KIW-1:0];
   end

   serial_capture_reg #(.W(BLOCK_W), .IW(DIW)) u_data_reg (
      .clk    (clk),
      .reset  (reset),
      .en     (data_en),
      .idx    (data_idx),
      .bit_in (mosi),
      .q      (data_out)
   );

   serial_capture_reg #(.W(KEY_W), .IW(KIW)) u_key_reg (
      .clk    (clk),
      .reset  (reset),
      .en     (key_en),
      .idx    (key_idx),
      .bit_in (mosi),
      .q      (key_out)
   );

   // Frame sequencing; busy and out_valid are registered alongside the state so
   // they always reflect the state the loader is actually in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!cs) begin
                  state   <= DATA;
                  bit_cnt <= CNT_W'(1);
                  busy    <= 1'b1;
               end
            end
            DATA: begin
               if (cs) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (bit_cnt == LAST_DATA) begin
                  state   <= KEY;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            KEY: begin
               if (cs) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (bit_cnt == LAST_KEY) begin
                  state     <= HOLD;
                  bit_cnt   <= '0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            HOLD: begin
               // A bit arriving here is an overrun even if the handshake completes now.
               if (!cs) begin
                  frame_err <= 1'b1;
               end
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               bit_cnt   <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
